// File: rtl/mem_lsq_buffer.sv
// In-order load/store buffer between issue and the memory unit; snoops the CDB and dispatches head.
// Optional LSQ_PERF_CNT_EN adds saturating stall/full cycle counters.
module mem_lsq_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic                     issue_op,
  input  logic [TAGW-1:0]          issue_base_tag,
  input  logic [31:0]              issue_base_val,
  input  logic [TAGW-1:0]          issue_data_tag,
  input  logic [31:0]              issue_data_val,
  input  logic [31:0]              issue_offset,
  input  logic [TAGW-1:0]          issue_label,
  output logic                     buf_full,
  input  logic                     cdb_valid,
  input  logic [TAGW-1:0]          cdb_label,
  input  logic [31:0]              cdb_data,
  output logic                     mem_wen,
  output logic [31:0]              mem_base,
  output logic [31:0]              mem_offset,
  output logic                     mem_op,
  output logic [31:0]              mem_write_data,
  output logic [TAGW-1:0]          mem_label,
  input  logic                     mem_available,
`ifdef LSQ_PERF_CNT_EN
  output logic [15:0]              stall_cycles,
  output logic [15:0]              full_cycles,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_op;
  logic [TAGW-1:0]  ent_base_tag [DEPTH];
  logic [31:0]      ent_base_val [DEPTH];
  logic [TAGW-1:0]  ent_data_tag [DEPTH];
  logic [31:0]      ent_data_val [DEPTH];
  logic [31:0]      ent_offset   [DEPTH];
  logic [TAGW-1:0]  ent_label    [DEPTH];

  logic            head_ready;
  logic            do_issue;
  logic            do_dispatch;
  logic            byp_base, byp_data;
  logic [TAGW-1:0] new_base_tag, new_data_tag;
  logic [31:0]     new_base_val, new_data_val;

  always_comb begin
    buf_full   = (count_q == CntW'(DEPTH));
    head_ready = ent_valid[head_q] && (ent_base_tag[head_q] == '0) &&
                 (ent_op[head_q] || (ent_data_tag[head_q] == '0));
    mem_wen    = (count_q != '0) && head_ready;

    mem_base       = '0;
    mem_offset     = '0;
    mem_op         = 1'b0;
    mem_write_data = '0;
    mem_label      = '0;
    if (mem_wen) begin
      mem_base       = ent_base_val[head_q];
      mem_offset     = ent_offset[head_q];
      mem_op         = ent_op[head_q];
      mem_write_data = ent_data_val[head_q];
      mem_label      = ent_label[head_q];
    end

    do_issue    = issue_valid && !buf_full;
    do_dispatch = mem_wen && mem_available;

    // A producer broadcasting in the issue cycle would otherwise be missed forever.
    byp_base     = cdb_valid && (issue_base_tag != '0) && (cdb_label == issue_base_tag);
    byp_data     = cdb_valid && (issue_data_tag != '0) && (cdb_label == issue_data_tag);
    new_base_tag = byp_base ? '0 : issue_base_tag;
    new_base_val = byp_base ? cdb_data : issue_base_val;
    new_data_tag = byp_data ? '0 : issue_data_tag;
    new_data_val = byp_data ? cdb_data : issue_data_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ent_valid <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ent_valid[i] && cdb_valid) begin
          if ((ent_base_tag[i] != '0) && (ent_base_tag[i] == cdb_label)) begin
            ent_base_tag[i] <= '0;
            ent_base_val[i] <= cdb_data;
          end
          if ((ent_data_tag[i] != '0) && (ent_data_tag[i] == cdb_label)) begin
            ent_data_tag[i] <= '0;
            ent_data_val[i] <= cdb_data;
          end
        end
      end

      if (do_dispatch) begin
        ent_valid[head_q] <= 1'b0;
        head_q            <= head_q + PtrW'(1);
      end

      // Tail slot is never valid when not full, so this cannot collide with the snoop above.
      if (do_issue) begin
        ent_valid[tail_q]    <= 1'b1;
        ent_op[tail_q]       <= issue_op;
        ent_base_tag[tail_q] <= new_base_tag;
        ent_base_val[tail_q] <= new_base_val;
        ent_data_tag[tail_q] <= new_data_tag;
        ent_data_val[tail_q] <= new_data_val;
        ent_offset[tail_q]   <= issue_offset;
        ent_label[tail_q]    <= issue_label;
        tail_q               <= tail_q + PtrW'(1);
      end

      unique case ({do_issue, do_dispatch})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count = count_q;

`ifdef LSQ_PERF_CNT_EN
  logic [15:0] stall_q, full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      full_q  <= '0;
    end else begin
      if ((count_q != '0) && !do_dispatch && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      if (buf_full && (full_q != 16'hFFFF)) begin
        full_q <= full_q + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign full_cycles  = full_q;
`endif

endmodule

// File: tb/tb_mem_lsq_buffer.sv
// Directed table-driven bench for mem_lsq_buffer, plus a hand-written mid-operation reset sequence.
module tb_mem_lsq_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAGW  = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   issue_valid, issue_op;
  logic [TAGW-1:0]        issue_base_tag, issue_data_tag, issue_label;
  logic [31:0]            issue_base_val, issue_data_val, issue_offset;
  logic                   buf_full;
  logic                   cdb_valid;
  logic [TAGW-1:0]        cdb_label;
  logic [31:0]            cdb_data;
  logic                   mem_wen, mem_op, mem_available;
  logic [31:0]            mem_base, mem_offset, mem_write_data;
  logic [TAGW-1:0]        mem_label;
  logic [$clog2(DEPTH):0] count;
`ifdef LSQ_PERF_CNT_EN
  logic [15:0]            stall_cycles, full_cycles;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_lsq_buffer #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_op       (issue_op),
    .issue_base_tag (issue_base_tag),
    .issue_base_val (issue_base_val),
    .issue_data_tag (issue_data_tag),
    .issue_data_val (issue_data_val),
    .issue_offset   (issue_offset),
    .issue_label    (issue_label),
    .buf_full       (buf_full),
    .cdb_valid      (cdb_valid),
    .cdb_label      (cdb_label),
    .cdb_data       (cdb_data),
    .mem_wen        (mem_wen),
    .mem_base       (mem_base),
    .mem_offset     (mem_offset),
    .mem_op         (mem_op),
    .mem_write_data (mem_write_data),
    .mem_label      (mem_label),
    .mem_available  (mem_available),
`ifdef LSQ_PERF_CNT_EN
    .stall_cycles   (stall_cycles),
    .full_cycles    (full_cycles),
`endif
    .count          (count)
  );

  typedef struct packed {
    logic        v;
    logic        op;
    logic [3:0]  bt;
    logic [31:0] bv;
    logic [3:0]  dt;
    logic [31:0] dv;
    logic [31:0] off;
    logic [3:0]  lab;
  } iss_t;

  typedef struct packed {
    logic [2:0]  cnt;
    logic        full;
    logic        wen;
    logic [31:0] base;
    logic [31:0] off;
    logic        op;
    logic [31:0] wd;
    logic [3:0]  lab;
  } exp_t;

  typedef struct {
    iss_t        iss;
    logic        cv;
    logic [3:0]  cl;
    logic [31:0] cd;
    logic        avail;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];
  iss_t ni;

  function automatic iss_t mk_iss(logic op, logic [3:0] bt, logic [31:0] bv, logic [3:0] dt,
                                  logic [31:0] dv, logic [31:0] off, logic [3:0] lab);
    iss_t r;
    r.v = 1'b1; r.op = op; r.bt = bt; r.bv = bv; r.dt = dt; r.dv = dv; r.off = off; r.lab = lab;
    return r;
  endfunction

  function automatic exp_t ex(logic [2:0] cnt, logic full, logic wen, logic [31:0] base,
                              logic [31:0] off, logic op, logic [31:0] wd, logic [3:0] lab);
    exp_t r;
    r.cnt = cnt; r.full = full; r.wen = wen; r.base = base; r.off = off; r.op = op;
    r.wd = wd; r.lab = lab;
    return r;
  endfunction

  // Expected state with no dispatchable head.
  function automatic exp_t ew(logic [2:0] cnt, logic full);
    return ex(cnt, full, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 4'h0);
  endfunction

  function automatic iss_t ld(logic [3:0] lab);
    return mk_iss(1'b1, 4'h0, 32'h1000 + 32'(lab), 4'h0, 32'h0, 32'(lab), lab);
  endfunction

  function automatic exp_t hd(logic [2:0] cnt, logic full, logic [3:0] lab);
    return ex(cnt, full, 1'b1, 32'h1000 + 32'(lab), 32'(lab), 1'b1, 32'h0, lab);
  endfunction

  task automatic add(iss_t i, logic cv, logic [3:0] cl, logic [31:0] cd, logic av, exp_t e);
    vec_t v;
    v.iss = i; v.cv = cv; v.cl = cl; v.cd = cd; v.avail = av; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic drive(iss_t i, logic cv, logic [3:0] cl, logic [31:0] cd, logic av);
    issue_valid    = i.v;
    issue_op       = i.op;
    issue_base_tag = i.bt;
    issue_base_val = i.bv;
    issue_data_tag = i.dt;
    issue_data_val = i.dv;
    issue_offset   = i.off;
    issue_label    = i.lab;
    cdb_valid      = cv;
    cdb_label      = cl;
    cdb_data       = cd;
    mem_available  = av;
  endtask

  task automatic check(string nm, exp_t e);
    logic bad;
    tests++;
    bad = (count !== e.cnt) || (buf_full !== e.full) || (mem_wen !== e.wen);
    if (e.wen && ({mem_base, mem_offset, mem_op, mem_write_data, mem_label} !==
                  {e.base, e.off, e.op, e.wd, e.lab})) bad = 1'b1;
    if (bad) begin
      fails++;
      $display("FAIL %s: got cnt=%0d full=%0b wen=%0b base=%h off=%h op=%0b wd=%h lab=%0d | want cnt=%0d full=%0b wen=%0b base=%h off=%h op=%0b wd=%h lab=%0d",
               nm, count, buf_full, mem_wen, mem_base, mem_offset, mem_op, mem_write_data,
               mem_label, e.cnt, e.full, e.wen, e.base, e.off, e.op, e.wd, e.lab);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ni = '0;
    drive(ni, 1'b0, 4'h0, 32'h0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset", ew(3'd0, 1'b0));

    // Ready load dispatches the cycle after issue.
    add(mk_iss(1, 0, 'h100, 0, 0, 'h4, 3), 0, 0, 0, 1, ex(1, 0, 1, 'h100, 'h4, 1, 0, 3));
    add(ni, 0, 0, 0, 1, ew(0, 0));
    // Store waiting on base tag 5.
    add(mk_iss(0, 5, 0, 0, 'hAB, 'h10, 4), 0, 0, 0, 1, ew(1, 0));
    add(ni, 0, 0, 0, 1, ew(1, 0));
    add(ni, 1, 5, 'h200, 1, ex(1, 0, 1, 'h200, 'h10, 0, 'hAB, 4));
    add(ni, 0, 0, 0, 1, ew(0, 0));
    // Issue-cycle CDB bypass.
    add(mk_iss(1, 7, 0, 0, 0, 'h8, 6), 1, 7, 'h55, 0, ex(1, 0, 1, 'h55, 'h8, 1, 0, 6));
    add(ni, 0, 0, 0, 1, ew(0, 0));
    // Stalled head blocks a ready younger entry.
    add(mk_iss(1, 2, 0, 0, 0, 'h20, 8), 0, 0, 0, 1, ew(1, 0));
    add(mk_iss(0, 0, 'h300, 0, 'h77, 'h24, 9), 0, 0, 0, 1, ew(2, 0));
    add(ni, 0, 0, 0, 1, ew(2, 0));
    add(ni, 1, 2, 'h400, 1, ex(2, 0, 1, 'h400, 'h20, 1, 0, 8));
    add(ni, 0, 0, 0, 1, ex(1, 0, 1, 'h300, 'h24, 0, 'h77, 9));
    add(ni, 0, 0, 0, 1, ew(0, 0));
    // CDB label 0 never matches.
    add(mk_iss(1, 0, 'h11, 0, 0, 0, 1), 1, 0, 'hDEAD, 0, ex(1, 0, 1, 'h11, 0, 1, 0, 1));
    add(ni, 1, 0, 'hBEEF, 0, ex(1, 0, 1, 'h11, 0, 1, 0, 1));
    add(ni, 0, 0, 0, 1, ew(0, 0));
    // Store data tag snoop.
    add(mk_iss(0, 0, 'h500, 3, 0, 0, 2), 0, 0, 0, 0, ew(1, 0));
    add(ni, 1, 3, 'h66, 0, ex(1, 0, 1, 'h500, 0, 0, 'h66, 2));
    add(ni, 0, 0, 0, 1, ew(0, 0));
    // Load ignores its data tag.
    add(mk_iss(1, 0, 'h600, 9, 0, 'h4, 5), 0, 0, 0, 0, ex(1, 0, 1, 'h600, 'h4, 1, 0, 5));
    add(ni, 0, 0, 0, 1, ew(0, 0));
    // Fill to full, drop the 5th, then stream with concurrent issue across the wrap.
    add(ld(1), 0, 0, 0, 0, hd(1, 0, 1));
    add(ld(2), 0, 0, 0, 0, hd(2, 0, 1));
    add(ld(3), 0, 0, 0, 0, hd(3, 0, 1));
    add(ld(4), 0, 0, 0, 0, hd(4, 1, 1));
    add(ld(5), 0, 0, 0, 0, hd(4, 1, 1));
    add(ld(5), 0, 0, 0, 1, hd(3, 0, 2));
    add(ld(5), 0, 0, 0, 1, hd(3, 0, 3));
    for (int k = 6; k <= 11; k++) add(ld(4'(k)), 0, 0, 0, 1, hd(3, 0, 4'(k - 2)));
    add(ni, 0, 0, 0, 1, hd(2, 0, 10));
    add(ni, 0, 0, 0, 1, hd(1, 0, 11));
    add(ni, 0, 0, 0, 1, ew(0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].iss, vecs[i].cv, vecs[i].cl, vecs[i].cd, vecs[i].avail);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].e);
    end

    // Reset with three waiting entries held.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(mk_iss(1, 1, 0, 0, 0, 0, 4'(k + 1)), 0, 0, 0, 0);
    end
    @(posedge clk);
    #1;
    check("rst_fill", ew(3, 0));
    @(negedge clk);
    drive(ni, 0, 0, 0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid", ew(0, 0));
    @(negedge clk);
    rst = 1'b0;
    drive(mk_iss(1, 0, 'h900, 0, 0, 'hC, 12), 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("rst_issue", ex(1, 0, 1, 'h900, 'hC, 1, 0, 12));
    @(negedge clk);
    drive(ni, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    check("rst_drain", ew(0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
